wbk_stage: RTL and testbench
============================

Name: wbk_stage

Overview:
- Writeback stage; sits directly downstream of the memory stage and drains the mem2wbk FIFO.
- Selects the final register-file write value from one of three sources: memory/ALU result, multiplier pipeline result, or the old CSR value.
- Drives the register-file write port and a registered copy of that write for decode bypass.
- Sequences the join with the multiplier output FIFO, with a watchdog, and keeps a commit counter.

Parameters:
- MULT_TIMEOUT, 64: max cycles in S_WAIT_MULT before the timeout error flag sets; must be >= 2.
- CNT_W, 64: width of the commit counter.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
MEM_RES_RM  in  32  FIFO head: load data / ALU result
MEM_DEST_RM  in  6  FIFO head: destination register
WB_RM  in  1  FIFO head: register write requested
CSR_WENABLE_RM  in  1  FIFO head: CSR instruction, rd receives old CSR value
CSR_RDATA_RM  in  32  FIFO head: old CSR value
MULT_INST_RM  in  1  FIFO head: result comes from the multiplier
MEM2WBK_EMPTY_SM  in  1  mem2wbk FIFO empty
MEM2WBK_POP_SW  out  1  pop mem2wbk FIFO
MULT_RES_RX2  in  32  multiplier output FIFO head
X22WBK_EMPTY_SX2  in  1  multiplier output FIFO empty
X22WBK_POP_SW  out  1  pop multiplier output FIFO
WBK_DATA_SW  out  32  register-file write data (combinational)
WBK_DEST_SW  out  6  register-file write address (combinational)
WBK_EN_SW  out  1  register-file write enable (combinational)
BP_DATA_RW  out  32  registered copy of the last write, for decode bypass
BP_DEST_RW  out  6  registered destination
BP_VALID_RW  out  1  registered valid
WBK_STALL_SW  out  1  head is a mult op and its result is absent
MULT_TIMEOUT_RW  out  1  sticky watchdog error
COMMIT_CNT_RW  out  CNT_W  count of consumed mem2wbk entries

Behaviour:
- Reset: all registered outputs are 0; FSM enters S_RUN; watchdog counter is 0.
- Head valid: head_v = !MEM2WBK_EMPTY_SM.
- Non-mult head (MULT_INST_RM=0), head_v=1:
  - MEM2WBK_POP_SW=1 in the same cycle; zero added latency.
  - X22WBK_POP_SW=0.
- Mult head, head_v=1, !X22WBK_EMPTY_SX2:
  - Both POPs assert in the same cycle.
  - Data source is MULT_RES_RX2.
- Mult head, head_v=1, X22WBK_EMPTY_SX2=1:
  - No pop; WBK_STALL_SW=1.
  - FSM goes to S_WAIT_MULT.
- S_WAIT_MULT:
  - Watchdog increments every cycle.
  - On !X22WBK_EMPTY_SX2: both POPs assert, write completes, watchdog clears, FSM returns to S_RUN.
  - If the watchdog reaches MULT_TIMEOUT: MULT_TIMEOUT_RW sets and stays set until reset; FSM keeps waiting.
- X2 FIFO non-empty while the head is not a mult op: never pop it.
- Data select priority:
  - CSR_WENABLE_RM -> CSR_RDATA_RM.
  - else MULT_INST_RM -> MULT_RES_RX2.
  - else MEM_RES_RM.
- Write port:
  - WBK_EN_SW = MEM2WBK_POP_SW && WB_RM && (MEM_DEST_RM != 0); writes to x0 are suppressed.
  - WBK_DEST_SW = MEM_DEST_RM.
  - WBK_DATA_SW = selected data.
- Bypass registers: every cycle capture WBK_EN_SW into BP_VALID_RW. Capture data/dest only when WBK_EN_SW=1; otherwise hold them. One-cycle latency.
- COMMIT_CNT_RW: +1 on each MEM2WBK_POP_SW; wraps modulo 2^CNT_W.
- Empty FIFO: no pop, no write, no state change, even if the X2 FIFO is non-empty.
- Reset asserted in S_WAIT_MULT: immediate return to S_RUN. Counters and flags clear; no pop is issued.
- Any combination of non-empty FIFOs pops at most one entry per FIFO per cycle.

Optional Feature:
- Macro WBK_PERF_EN.
- Defined:
  - Adds output MULT_WAIT_CNT_RW (32 bits), reset 0.
  - Increments each cycle WBK_STALL_SW=1; saturates at 0xFFFFFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package wbk_pkg holds:
  - state enum wbk_state_t {S_RUN, S_WAIT_MULT};
  - source-select enum wbk_src_t {SRC_MEM, SRC_MULT, SRC_CSR};
  - constant REG_ZERO = 6'd0.
- One sub-module, wbk_watchdog: counter plus sticky flag, parameterised by MULT_TIMEOUT, inputs clk/reset_n/run/clear.

Test Plan:
- Non-mult load: head MEM_RES_RM=0x00000080, dest=5, WB=1 -> same cycle POP=1, WBK_EN=1, data 0x80 to x5; next cycle BP_VALID_RW=1, BP_DEST_RW=5; COMMIT_CNT_RW=1.
- CSR read: CSR_WENABLE=1, CSR_RDATA=0x1800, MEM_RES=0xDEAD, dest=7 -> WBK_DATA_SW=0x1800.
- Mult join, late result: mult head, X2 empty for 3 cycles, then MULT_RES_RX2=0x12345678 -> WBK_STALL_SW=1 for 3 cycles, no pops. Then both pops in one cycle, dest written with 0x12345678; with WBK_PERF_EN, MULT_WAIT_CNT_RW=3.
- Watchdog: MULT_TIMEOUT=4, X2 empty for 10 cycles -> MULT_TIMEOUT_RW=1 from cycle 4 and stays set after the result arrives.
- x0 suppression: dest=0, WB=1 -> POP=1, WBK_EN_SW=0, BP_VALID_RW=0, COMMIT_CNT_RW increments.
- Reset mid-wait: reset_n low in S_WAIT_MULT -> all outputs 0, no pop; after release, a mult head with X2 non-empty completes in 1 cycle.

Source files
------------

// File: rtl/wbk_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : wbk_pkg                                                   |
// | Purpose  : Shared types and constants for the writeback stage.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package wbk_pkg;

    typedef enum logic [0:0] {
        S_RUN       = 1'b0,
        S_WAIT_MULT = 1'b1
    } wbk_state_t;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_MULT = 2'd1,
        SRC_CSR  = 2'd2
    } wbk_src_t;

    localparam logic [5:0] REG_ZERO = 6'd0;

    // CSR instructions return the old CSR value even if also tagged as mult.
    function automatic wbk_src_t wbk_sel_src(input logic csr_en, input logic mult);
        wbk_src_t src;
        if (csr_en)
            src = SRC_CSR;
        else if (mult)
            src = SRC_MULT;
        else
            src = SRC_MEM;
        return src;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbk_watchdog.sv
// +----------------------------------------------------------------------+
// | Module   : wbk_watchdog                                              |
// | Purpose  : Stall-cycle counter with a sticky timeout flag.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module wbk_watchdog #(
    parameter int MULT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic timeout
);

    localparam int                c_WD_W  = $clog2(MULT_TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_LIMIT = c_WD_W'(MULT_TIMEOUT);

    logic [c_WD_W-1:0] r_cnt;

    // Counter saturates at the limit so a long wait never wraps it back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            timeout <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == (c_LIMIT - 1'b1))
                timeout <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wbk_stage.sv
// +----------------------------------------------------------------------+
// | Module   : wbk_stage                                                 |
// | Purpose  : Writeback stage: drains mem2wbk, joins multiplier results,|
// |            drives the register-file write port and decode bypass.    |
// |            Optional WBK_PERF_EN adds a stall-cycle counter output.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module wbk_stage
    import wbk_pkg::*;
#(
    parameter int MULT_TIMEOUT = 64,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      MEM_RES_RM,
    input  logic [5:0]       MEM_DEST_RM,
    input  logic             WB_RM,
    input  logic             CSR_WENABLE_RM,
    input  logic [31:0]      CSR_RDATA_RM,
    input  logic             MULT_INST_RM,
    input  logic             MEM2WBK_EMPTY_SM,
    output logic             MEM2WBK_POP_SW,
    input  logic [31:0]      MULT_RES_RX2,
    input  logic             X22WBK_EMPTY_SX2,
    output logic             X22WBK_POP_SW,
    output logic [31:0]      WBK_DATA_SW,
    output logic [5:0]       WBK_DEST_SW,
    output logic             WBK_EN_SW,
    output logic [31:0]      BP_DATA_RW,
    output logic [5:0]       BP_DEST_RW,
    output logic             BP_VALID_RW,
    output logic             WBK_STALL_SW,
    output logic             MULT_TIMEOUT_RW,
    output logic [CNT_W-1:0] COMMIT_CNT_RW
`ifdef WBK_PERF_EN
    ,
    output logic [31:0]      MULT_WAIT_CNT_RW
`endif
);

    wbk_state_t r_state;
    wbk_src_t   w_src;
    logic       w_head_v;
    logic       w_x2_v;
    logic       w_pop_mem;
    logic       w_pop_x2;
    logic       w_stall;

    // Qualifying with reset_n keeps every pop and write quiet while reset is held.
    assign w_head_v  = !MEM2WBK_EMPTY_SM && reset_n;
    assign w_x2_v    = !X22WBK_EMPTY_SX2;
    assign w_pop_mem = w_head_v && (!MULT_INST_RM || w_x2_v);
    assign w_pop_x2  = w_head_v && MULT_INST_RM && w_x2_v;
    assign w_stall   = w_head_v && MULT_INST_RM && !w_x2_v;

    assign MEM2WBK_POP_SW = w_pop_mem;
    assign X22WBK_POP_SW  = w_pop_x2;
    assign WBK_STALL_SW   = w_stall;

    assign w_src = wbk_sel_src(CSR_WENABLE_RM, MULT_INST_RM);

    always_comb begin
        WBK_DATA_SW = MEM_RES_RM;
        case (w_src)
            SRC_CSR:  WBK_DATA_SW = CSR_RDATA_RM;
            SRC_MULT: WBK_DATA_SW = MULT_RES_RX2;
            default:  WBK_DATA_SW = MEM_RES_RM;
        endcase
    end

    assign WBK_DEST_SW = MEM_DEST_RM;
    assign WBK_EN_SW   = w_pop_mem && WB_RM && (MEM_DEST_RM != REG_ZERO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN:       if (w_stall)  r_state <= S_WAIT_MULT;
                S_WAIT_MULT: if (w_pop_x2) r_state <= S_RUN;
                default:     r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            BP_VALID_RW   <= 1'b0;
            BP_DATA_RW    <= '0;
            BP_DEST_RW    <= '0;
            COMMIT_CNT_RW <= '0;
        end else begin
            BP_VALID_RW <= WBK_EN_SW;
            if (WBK_EN_SW) begin
                BP_DATA_RW <= WBK_DATA_SW;
                BP_DEST_RW <= WBK_DEST_SW;
            end
            if (w_pop_mem)
                COMMIT_CNT_RW <= COMMIT_CNT_RW + CNT_W'(1);
        end
    end

    // Watchdog counts every stalled cycle, including the one that enters the wait.
    wbk_watchdog #(
        .MULT_TIMEOUT (MULT_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (w_stall),
        .clear   (w_pop_x2),
        .timeout (MULT_TIMEOUT_RW)
    );

`ifdef WBK_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            MULT_WAIT_CNT_RW <= '0;
        else if (w_stall && (MULT_WAIT_CNT_RW != 32'hFFFF_FFFF))
            MULT_WAIT_CNT_RW <= MULT_WAIT_CNT_RW + 32'd1;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wbk_stage.sv
// +----------------------------------------------------------------------+
// | Module   : tb_wbk_stage                                              |
// | Purpose  : Directed vector bench for wbk_stage (WBK_PERF_EN aware).  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wbk_stage;

    localparam int c_TO    = 4;
    localparam int c_CNT_W = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [31:0]        MEM_RES_RM;
    logic [5:0]         MEM_DEST_RM;
    logic               WB_RM;
    logic               CSR_WENABLE_RM;
    logic [31:0]        CSR_RDATA_RM;
    logic               MULT_INST_RM;
    logic               MEM2WBK_EMPTY_SM;
    logic               MEM2WBK_POP_SW;
    logic [31:0]        MULT_RES_RX2;
    logic               X22WBK_EMPTY_SX2;
    logic               X22WBK_POP_SW;
    logic [31:0]        WBK_DATA_SW;
    logic [5:0]         WBK_DEST_SW;
    logic               WBK_EN_SW;
    logic [31:0]        BP_DATA_RW;
    logic [5:0]         BP_DEST_RW;
    logic               BP_VALID_RW;
    logic               WBK_STALL_SW;
    logic               MULT_TIMEOUT_RW;
    logic [c_CNT_W-1:0] COMMIT_CNT_RW;
`ifdef WBK_PERF_EN
    logic [31:0]        MULT_WAIT_CNT_RW;
`endif

    always #5 clk = ~clk;

    wbk_stage #(
        .MULT_TIMEOUT (c_TO),
        .CNT_W        (c_CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .MEM_RES_RM       (MEM_RES_RM),
        .MEM_DEST_RM      (MEM_DEST_RM),
        .WB_RM            (WB_RM),
        .CSR_WENABLE_RM   (CSR_WENABLE_RM),
        .CSR_RDATA_RM     (CSR_RDATA_RM),
        .MULT_INST_RM     (MULT_INST_RM),
        .MEM2WBK_EMPTY_SM (MEM2WBK_EMPTY_SM),
        .MEM2WBK_POP_SW   (MEM2WBK_POP_SW),
        .MULT_RES_RX2     (MULT_RES_RX2),
        .X22WBK_EMPTY_SX2 (X22WBK_EMPTY_SX2),
        .X22WBK_POP_SW    (X22WBK_POP_SW),
        .WBK_DATA_SW      (WBK_DATA_SW),
        .WBK_DEST_SW      (WBK_DEST_SW),
        .WBK_EN_SW        (WBK_EN_SW),
        .BP_DATA_RW       (BP_DATA_RW),
        .BP_DEST_RW       (BP_DEST_RW),
        .BP_VALID_RW      (BP_VALID_RW),
        .WBK_STALL_SW     (WBK_STALL_SW),
        .MULT_TIMEOUT_RW  (MULT_TIMEOUT_RW),
        .COMMIT_CNT_RW    (COMMIT_CNT_RW)
`ifdef WBK_PERF_EN
        ,
        .MULT_WAIT_CNT_RW (MULT_WAIT_CNT_RW)
`endif
    );

    typedef struct {
        logic        empty;
        logic        mult;
        logic        x2_empty;
        logic        csr_en;
        logic        wb;
        logic [5:0]  dest;
        logic [31:0] mem_res;
        logic [31:0] csr_rdata;
        logic [31:0] mult_res;
        logic        exp_pop;
        logic        exp_pop_x2;
        logic        exp_en;
        logic [31:0] exp_data;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[8];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_commit = 0;
    logic [31:0] exp_bp_data = '0;
    logic [5:0]  exp_bp_dest = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic empty, input logic mult, input logic x2_empty,
                         input logic csr_en, input logic wb, input logic [5:0] dest,
                         input logic [31:0] mem_res, input logic [31:0] csr_rdata,
                         input logic [31:0] mult_res);
        MEM2WBK_EMPTY_SM = empty;
        MULT_INST_RM     = mult;
        X22WBK_EMPTY_SX2 = x2_empty;
        CSR_WENABLE_RM   = csr_en;
        WB_RM            = wb;
        MEM_DEST_RM      = dest;
        MEM_RES_RM       = mem_res;
        CSR_RDATA_RM     = csr_rdata;
        MULT_RES_RX2     = mult_res;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();

        //                empty mult x2e csr wb dest mem_res       csr_rdata     mult_res      pop x2p en data          stall
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  32'h0000_0080, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd7,  32'h0000_DEAD, 32'h0000_1800, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_1800, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0,  32'h0000_0055, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0055, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4,  32'h0000_0011, 32'h0,        32'h0000_0777, 1'b0, 1'b0, 1'b0, 32'h0000_0777, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd9,  32'h0000_1234, 32'h0,        32'h0000_0999, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 32'h0000_0001, 32'h0,        32'hCAFE_0001, 1'b1, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd11, 32'h0000_0002, 32'h0000_ABCD, 32'h0000_5555, 1'b1, 1'b1, 1'b1, 32'h0000_ABCD, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd12, 32'h0000_0003, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0003, 1'b0};

        // Reset state
        step();
        step();
        chk("rst_bp_valid", 64'(BP_VALID_RW), 64'd0);
        chk("rst_bp_data",  64'(BP_DATA_RW),  64'd0);
        chk("rst_bp_dest",  64'(BP_DEST_RW),  64'd0);
        chk("rst_commit",   64'(COMMIT_CNT_RW), 64'd0);
        chk("rst_timeout",  64'(MULT_TIMEOUT_RW), 64'd0);
`ifdef WBK_PERF_EN
        chk("rst_wait_cnt", 64'(MULT_WAIT_CNT_RW), 64'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Table-driven single-cycle vectors
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].empty, vecs[i].mult, vecs[i].x2_empty, vecs[i].csr_en, vecs[i].wb,
                  vecs[i].dest, vecs[i].mem_res, vecs[i].csr_rdata, vecs[i].mult_res);
            @(negedge clk);
            chk($sformatf("v%0d_pop", i),    64'(MEM2WBK_POP_SW), 64'(vecs[i].exp_pop));
            chk($sformatf("v%0d_pop_x2", i), 64'(X22WBK_POP_SW),  64'(vecs[i].exp_pop_x2));
            chk($sformatf("v%0d_en", i),     64'(WBK_EN_SW),      64'(vecs[i].exp_en));
            chk($sformatf("v%0d_data", i),   64'(WBK_DATA_SW),    64'(vecs[i].exp_data));
            chk($sformatf("v%0d_dest", i),   64'(WBK_DEST_SW),    64'(vecs[i].dest));
            chk($sformatf("v%0d_stall", i),  64'(WBK_STALL_SW),   64'(vecs[i].exp_stall));
            if (vecs[i].exp_pop)
                exp_commit++;
            if (vecs[i].exp_en) begin
                exp_bp_data = vecs[i].exp_data;
                exp_bp_dest = vecs[i].dest;
            end
            step();
            chk($sformatf("v%0d_bp_valid", i), 64'(BP_VALID_RW), 64'(vecs[i].exp_en));
            chk($sformatf("v%0d_bp_data", i),  64'(BP_DATA_RW),  64'(exp_bp_data));
            chk($sformatf("v%0d_bp_dest", i),  64'(BP_DEST_RW),  64'(exp_bp_dest));
            chk($sformatf("v%0d_commit", i),   64'(COMMIT_CNT_RW), 64'(exp_commit % 16));
        end

        // Mult join with the result arriving after three stalled cycles
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd3, 32'h0000_0044, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("late_stall%0d", k),  64'(WBK_STALL_SW),   64'd1);
            chk($sformatf("late_pop%0d", k),    64'(MEM2WBK_POP_SW), 64'd0);
            chk($sformatf("late_pop_x2%0d", k), 64'(X22WBK_POP_SW),  64'd0);
            step();
        end
        chk("late_no_timeout", 64'(MULT_TIMEOUT_RW), 64'd0);
        MULT_RES_RX2     = 32'h1234_5678;
        X22WBK_EMPTY_SX2 = 1'b0;
        @(negedge clk);
        chk("late_join_pop",    64'(MEM2WBK_POP_SW), 64'd1);
        chk("late_join_pop_x2", 64'(X22WBK_POP_SW),  64'd1);
        chk("late_join_en",     64'(WBK_EN_SW),      64'd1);
        chk("late_join_data",   64'(WBK_DATA_SW),    64'h1234_5678);
        chk("late_join_stall",  64'(WBK_STALL_SW),   64'd0);
        exp_commit++;
        step();
        chk("late_bp_dest", 64'(BP_DEST_RW), 64'd3);
        chk("late_bp_data", 64'(BP_DATA_RW), 64'h1234_5678);
        chk("late_commit",  64'(COMMIT_CNT_RW), 64'(exp_commit % 16));
`ifdef WBK_PERF_EN
        chk("late_wait_cnt", 64'(MULT_WAIT_CNT_RW), 64'd3);
`endif
        idle();
        step();

        // Watchdog: ten empty cycles with the timeout at four
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd8, 32'h0, 32'h0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("wd_flag_after%0d", k), 64'(MULT_TIMEOUT_RW), (k >= c_TO) ? 64'd1 : 64'd0);
        end
        MULT_RES_RX2     = 32'h0BAD_F00D;
        X22WBK_EMPTY_SX2 = 1'b0;
        @(negedge clk);
        chk("wd_join_pop_x2", 64'(X22WBK_POP_SW), 64'd1);
        exp_commit++;
        step();
        idle();
        step();
        chk("wd_sticky", 64'(MULT_TIMEOUT_RW), 64'd1);
        chk("wd_commit", 64'(COMMIT_CNT_RW), 64'(exp_commit % 16));

        // Reset asserted while waiting on the multiplier
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd6, 32'h0, 32'h0, 32'h0);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("rstw_pop",      64'(MEM2WBK_POP_SW),  64'd0);
        chk("rstw_pop_x2",   64'(X22WBK_POP_SW),   64'd0);
        chk("rstw_stall",    64'(WBK_STALL_SW),    64'd0);
        chk("rstw_en",       64'(WBK_EN_SW),       64'd0);
        chk("rstw_bp_valid", 64'(BP_VALID_RW),     64'd0);
        chk("rstw_bp_data",  64'(BP_DATA_RW),      64'd0);
        chk("rstw_commit",   64'(COMMIT_CNT_RW),   64'd0);
        chk("rstw_timeout",  64'(MULT_TIMEOUT_RW), 64'd0);
        MULT_RES_RX2     = 32'h0000_4242;
        X22WBK_EMPTY_SX2 = 1'b0;
        @(negedge clk);
        chk("rstw_hold_pop", 64'(MEM2WBK_POP_SW), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rstw_rel_pop",    64'(MEM2WBK_POP_SW), 64'd1);
        chk("rstw_rel_pop_x2", 64'(X22WBK_POP_SW),  64'd1);
        chk("rstw_rel_data",   64'(WBK_DATA_SW),    64'h0000_4242);
        step();
        exp_commit = 1;
        chk("rstw_rel_bp_valid", 64'(BP_VALID_RW),   64'd1);
        chk("rstw_rel_bp_dest",  64'(BP_DEST_RW),    64'd6);
        chk("rstw_rel_commit",   64'(COMMIT_CNT_RW), 64'd1);
        idle();
        @(negedge clk);
        chk("idle_pop", 64'(MEM2WBK_POP_SW), 64'd0);
        step();

        // Commit counter wraps at its width
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd2, 32'h0000_0010, 32'h0, 32'h0);
        for (int k = 0; k < 15; k++)
            step();
        idle();
        chk("commit_wrap", 64'(COMMIT_CNT_RW), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
